ecc_ser: RTL and testbench

- Serializer directly downstream of ecc_enc.
- Accepts one full extended-Hamming code word, (n+1) bits wide, through a valid/ready handshake.
- Shifts the word out one bit per enabled clock, with a start-of-frame marker, a serial-valid qualifier and a programmable idle gap between frames.
- A one-word holding register allows back-to-back frames with no dead cycles.

---
 rtl/ecc_ser.sv | 123 ++++++++++++
 tb/tb_ecc_ser.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_ser.sv
// Serializer for extended-Hamming code words: one-word holding register feeding a
// shift engine with start-of-frame marker, serial-valid qualifier and fixed idle gap.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no frame in flight; loads as soon as the holding register fills
// ST_SHIFT | frame bits on sdo_o, bit_cnt tracks the bit currently presented
// ST_GAP   | forced idle between frames, gap_cnt counts down to zero

module ecc_ser #(
   parameter int K         = 26,
   parameter bit LSB_FIRST = 1'b1,
   parameter int GAP       = 0,
   parameter int CNT_W     = 16,
   // fixed point of m = clog2(K+1+m), reached in three iterations for any practical K
   localparam int M        = $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1))),
   localparam int W        = M + K + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clkena_i,
   input  logic [W-1:0]     d_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             sdo_o,
   output logic             sval_o,
   output logic             sof_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] frame_cnt_o
);

   localparam int              BC_W     = $clog2(W);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(W - 1);
   localparam logic [7:0]      GAP_LOAD = 8'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t          state;
   logic [W-1:0]    hr;
   logic [W-1:0]    sreg;
   logic            hr_full;
   logic [BC_W-1:0] bit_cnt;
   logic [7:0]      gap_cnt;
   logic            last_bit;
   logic            gap_done;
   logic            load;

   assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
   assign gap_done = (state == ST_GAP) && (gap_cnt == 8'd0);
   assign load     = hr_full && ((state == ST_IDLE) || (last_bit && (GAP == 0)) || gap_done);
   assign ready_o  = ~hr_full & clkena_i;
   assign busy_o   = (state != ST_IDLE);

   function automatic logic head(input logic [W-1:0] v);
      return LSB_FIRST ? v[0] : v[W-1];
   endfunction

   // sreg holds only the bits not yet presented, so the next bit is always at the head
   function automatic logic [W-1:0] advance(input logic [W-1:0] v);
      return LSB_FIRST ? (v >> 1) : (v << 1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         hr          <= '0;
         hr_full     <= 1'b0;
         sreg        <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         sdo_o       <= 1'b0;
         sval_o      <= 1'b0;
         sof_o       <= 1'b0;
         frame_cnt_o <= '0;
      end else if (clkena_i) begin
         if (load) begin
            hr_full <= 1'b0;
         end else if (valid_i && ready_o) begin
            hr      <= d_i;
            hr_full <= 1'b1;
         end

         if (last_bit) begin
            frame_cnt_o <= frame_cnt_o + 1'b1;
         end

         if (load) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            sreg    <= advance(hr);
            sdo_o   <= head(hr);
            sval_o  <= 1'b1;
            sof_o   <= 1'b1;
         end else begin
            case (state)
               ST_SHIFT: begin
                  if (last_bit) begin
                     state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                     gap_cnt <= GAP_LOAD;
                     sdo_o   <= 1'b0;
                     sval_o  <= 1'b0;
                     sof_o   <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     sreg    <= advance(sreg);
                     sdo_o   <= head(sreg);
                     sof_o   <= 1'b0;
                  end
               end
               ST_GAP: begin
                  if (gap_done) begin
                     state <= ST_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ecc_ser.sv
// Directed bench for ecc_ser: three instances (LSB-first, MSB-first, GAP=3) share stimulus,
// expected bits are queued at accept time and popped as serial bits appear.

module tb_ecc_ser;

   typedef struct {
      logic sof;
      logic b;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        clkena;
   logic [31:0] d;
   logic        valid;
   int          sel;

   logic        valid_a, ready_a, sdo_a, sval_a, sof_a, busy_a;
   logic        valid_b, ready_b, sdo_b, sval_b, sof_b, busy_b;
   logic        valid_c, ready_c, sdo_c, sval_c, sof_c, busy_c;
   logic [15:0] fcnt_a, fcnt_b, fcnt_c;

   logic        ready_m, sdo_m, sval_m, sof_m, busy_m;
   logic [15:0] fcnt_m;

   exp_t        exp_q[$];
   logic [31:0] word_q[$];
   int          n_pass;
   int          n_fail;
   int          n_total;
   int          got;
   int          max_run;
   int          sof_seen;
   int          gap_seen;
   int          ready_low;
   int          sval_seen;
   logic [7:0]  first8;

   assign valid_a = valid && (sel == 0);
   assign valid_b = valid && (sel == 1);
   assign valid_c = valid && (sel == 2);

   ecc_ser #(.K(26), .LSB_FIRST(1'b1), .GAP(0), .CNT_W(16)) u_lsb (
      .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d), .valid_i(valid_a),
      .ready_o(ready_a), .sdo_o(sdo_a), .sval_o(sval_a), .sof_o(sof_a), .busy_o(busy_a),
      .frame_cnt_o(fcnt_a));

   ecc_ser #(.K(26), .LSB_FIRST(1'b0), .GAP(0), .CNT_W(16)) u_msb (
      .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d), .valid_i(valid_b),
      .ready_o(ready_b), .sdo_o(sdo_b), .sval_o(sval_b), .sof_o(sof_b), .busy_o(busy_b),
      .frame_cnt_o(fcnt_b));

   ecc_ser #(.K(26), .LSB_FIRST(1'b1), .GAP(3), .CNT_W(16)) u_gap (
      .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d), .valid_i(valid_c),
      .ready_o(ready_c), .sdo_o(sdo_c), .sval_o(sval_c), .sof_o(sof_c), .busy_o(busy_c),
      .frame_cnt_o(fcnt_c));

   always_comb begin
      ready_m = ready_a;
      sdo_m   = sdo_a;
      sval_m  = sval_a;
      sof_m   = sof_a;
      busy_m  = busy_a;
      fcnt_m  = fcnt_a;
      case (sel)
         1: begin
            ready_m = ready_b; sdo_m = sdo_b; sval_m = sval_b;
            sof_m   = sof_b;   busy_m = busy_b; fcnt_m = fcnt_b;
         end
         2: begin
            ready_m = ready_c; sdo_m = sdo_c; sval_m = sval_c;
            sof_m   = sof_c;   busy_m = busy_c; fcnt_m = fcnt_c;
         end
         default: ;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      exp_t e;
      for (int i = 0; i < 32; i++) begin
         e.sof = (i == 0);
         e.b   = (sel == 1) ? w[31 - i] : w[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic feed(input int n);
      int waited;
      for (int i = 0; i < n; i++) begin
         waited = 0;
         d      = word_q[i];
         valid  = 1'b1;
         while (ready_m !== 1'b1 && waited < 200) begin
            ready_low++;
            @(negedge clk);
            waited++;
         end
         check("feed_timeout", 32'(waited < 200), 32'd1);
         push_word(word_q[i]);
         @(negedge clk);
      end
      valid = 1'b0;
   endtask

   task automatic drain(input int n, input int budget, input int stall_at);
      int   cycles;
      int   run;
      exp_t e;
      logic last_b;
      cycles   = 0;
      run      = 0;
      last_b   = 1'b0;
      got      = 0;
      max_run  = 0;
      sof_seen = 0;
      gap_seen = 0;
      first8   = '0;
      while (got < n && cycles < budget) begin
         if (sval_m === 1'b1) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
               check("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
               e      = exp_q.pop_front();
               last_b = e.b;
               check("sdo", 32'(sdo_m), 32'(e.b));
               check("sof", 32'(sof_m), 32'(e.sof));
            end
            if (sof_m === 1'b1) sof_seen++;
            if (got < 8) first8[got] = sdo_m;
            got++;
            if (got - 1 == stall_at) begin
               clkena = 1'b0;
               repeat (5) begin
                  @(negedge clk);
                  check("hold_sdo", 32'(sdo_m), 32'(last_b));
                  check("hold_sval", 32'(sval_m), 32'd1);
                  check("hold_ready", 32'(ready_m), 32'd0);
               end
               clkena = 1'b1;
            end
         end else begin
            run = 0;
            if (busy_m === 1'b1) gap_seen++;
         end
         if (got < n) begin
            @(negedge clk);
            cycles++;
         end
      end
      check("drain_count", 32'(got), 32'(n));
   endtask

   initial begin
      n_pass  = 0;
      n_fail  = 0;
      n_total = 0;
      sel     = 0;
      rst_n   = 1'b0;
      clkena  = 1'b1;
      valid   = 1'b0;
      d       = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_sdo", 32'(sdo_m), 32'd0);
      check("rst_sval", 32'(sval_m), 32'd0);
      check("rst_sof", 32'(sof_m), 32'd0);
      check("rst_busy", 32'(busy_m), 32'd0);
      check("rst_fcnt", 32'(fcnt_m), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(ready_m), 32'd1);

      // single LSB-first frame, latency and bit order
      sel   = 0;
      d     = 32'hA5C3_0F1E;
      valid = 1'b1;
      push_word(d);
      @(negedge clk);
      valid = 1'b0;
      check("t1_sval_early", 32'(sval_m), 32'd0);
      check("t1_ready_full", 32'(ready_m), 32'd0);
      @(negedge clk);
      check("t1_sof_first", 32'(sof_m), 32'd1);
      check("t1_sval_first", 32'(sval_m), 32'd1);
      drain(32, 100, -1);
      check("t1_first8", 32'(first8), 32'h1E);
      @(negedge clk);
      check("t1_fcnt", 32'(fcnt_m), 32'd1);
      check("t1_sval_end", 32'(sval_m), 32'd0);
      check("t1_busy_end", 32'(busy_m), 32'd0);

      // MSB-first instance, same word
      sel   = 1;
      d     = 32'hA5C3_0F1E;
      valid = 1'b1;
      push_word(d);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      drain(32, 100, -1);
      check("t2_first8", 32'(first8), 32'hA5);
      @(negedge clk);
      check("t2_fcnt", 32'(fcnt_m), 32'd1);

      // three back-to-back frames, valid held
      sel = 0;
      do_reset();
      word_q    = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
      ready_low = 0;
      fork
         feed(3);
         drain(96, 400, -1);
      join
      check("t3_run", 32'(max_run), 32'd96);
      check("t3_sofs", 32'(sof_seen), 32'd3);
      check("t3_ready_low", 32'(ready_low), 32'd32);
      @(negedge clk);
      check("t3_fcnt", 32'(fcnt_m), 32'd3);
      check("t3_busy_end", 32'(busy_m), 32'd0);

      // GAP=3 instance, two words
      sel = 2;
      do_reset();
      word_q = '{32'h1234_5678, 32'h9ABC_DEF0};
      fork
         feed(2);
         drain(64, 400, -1);
      join
      check("t4_gap", 32'(gap_seen), 32'd3);
      check("t4_sofs", 32'(sof_seen), 32'd2);
      check("t4_run", 32'(max_run), 32'd32);
      @(negedge clk);
      check("t4_fcnt", 32'(fcnt_m), 32'd2);

      // clock enable dropped for five cycles at bit 10
      sel = 0;
      do_reset();
      d     = 32'h3C5A_96E1;
      valid = 1'b1;
      push_word(d);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      drain(32, 100, 10);
      @(negedge clk);
      check("t5_fcnt", 32'(fcnt_m), 32'd1);
      check("t5_sval_end", 32'(sval_m), 32'd0);

      // reset at bit 17 with a second word held
      do_reset();
      word_q = '{32'hDEAD_BEEF, 32'h0F0F_1234};
      fork
         feed(2);
         drain(18, 100, -1);
      join
      rst_n = 1'b0;
      #1;
      check("t6_sdo", 32'(sdo_m), 32'd0);
      check("t6_sval", 32'(sval_m), 32'd0);
      check("t6_sof", 32'(sof_m), 32'd0);
      check("t6_busy", 32'(busy_m), 32'd0);
      check("t6_fcnt", 32'(fcnt_m), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t6_ready", 32'(ready_m), 32'd1);
      sval_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (sval_m !== 1'b0) sval_seen++;
      end
      check("t6_no_bits", 32'(sval_seen), 32'd0);
      check("t6_idle", 32'(busy_m), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
